// File: rtl/icache_line.sv
// Direct-mapped instruction cache with multi-word lines and a burst refill FSM.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module icache_line #(
    parameter int LINE_BITS  = 2,
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_flush,
    input  logic        cache_valid,
    output logic        cache_ready,
    input  logic [31:0] cache_addr,
    output logic [31:0] cache_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        busy
`ifdef ICACHE_STATS_EN
   ,output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int W        = 1 << LINE_BITS;
    localparam int L        = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - LINE_BITS - 2;

    typedef enum logic {IDLE, REFILL} state_e;

    typedef struct packed {
        logic [TAG_BITS-1:0]   tag;
        logic [INDEX_BITS-1:0] idx;
    } line_id_t;

    state_e                 state_q, state_d;
    line_id_t               req_q, req_d;
    logic [LINE_BITS-1:0]   cnt_q, cnt_d;
    logic                   abort_q, abort_d;
    logic [L-1:0]           valid_q, valid_d;
    logic                   data_we, tag_we;

    logic [TAG_BITS-1:0]    tag_mem  [L];
    logic [31:0]            data_mem [L*W];

    logic [LINE_BITS-1:0]   a_word;
    logic [INDEX_BITS-1:0]  a_idx;
    logic [TAG_BITS-1:0]    a_tag;
    logic                   hit;
    logic [1:0]             unused_addr_lsb;

    assign a_word          = cache_addr[LINE_BITS+1:2];
    assign a_idx           = cache_addr[INDEX_BITS+LINE_BITS+1:LINE_BITS+2];
    assign a_tag           = cache_addr[31:INDEX_BITS+LINE_BITS+2];
    assign unused_addr_lsb = cache_addr[1:0];

    assign hit         = cache_valid && valid_q[a_idx] && (tag_mem[a_idx] == a_tag);
    assign cache_rdata = data_mem[{a_idx, a_word}];
    assign mem_addr    = {req_q.tag, req_q.idx, cnt_q, 2'b00};
    assign busy        = (state_q == REFILL);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        valid_d     = valid_q;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        cache_ready = 1'b0;
        mem_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                cache_ready = hit;
                if (cache_valid && !hit) begin
                    req_d.tag = a_tag;
                    req_d.idx = a_idx;
                    cnt_d     = '0;
                    state_d   = REFILL;
                end
            end
            REFILL: begin
                mem_valid = 1'b1;
                // A flush mid-refill must not let the stale-epoch line become valid.
                if (cache_flush) abort_d = 1'b1;
                if (mem_ready) begin
                    data_we = 1'b1;
                    if (cnt_q == LINE_BITS'(W-1)) begin
                        tag_we             = 1'b1;
                        valid_d[req_q.idx] = !abort_q;
                        abort_d            = 1'b0;
                        state_d            = IDLE;
                    end else begin
                        cnt_d = cnt_q + LINE_BITS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush wins over a final-beat valid set in the same cycle.
        if (cache_flush) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= '0;
            abort_q <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && data_we) data_mem[{req_q.idx, cnt_q}] <= mem_rdata;
        if (!rst && tag_we)  tag_mem[req_q.idx]           <= req_q.tag;
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (state_q == IDLE && hit)                 hit_count_d  = hit_count_q + 32'd1;
        if (state_q == IDLE && state_d == REFILL)   miss_count_d = miss_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_line.sv
// Scoreboard bench for icache_line: fetched words are queued on request and
// compared when cache_ready fires; refill beat addresses are logged and checked.
module tb_icache_line;
    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cache_flush = 1'b0;
    logic        cache_valid = 1'b0;
    logic        cache_ready;
    logic [31:0] cache_addr = '0;
    logic [31:0] cache_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        busy;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_line #(.LINE_BITS(2), .INDEX_BITS(4)) dut (
        .clk(clk), .rst(rst), .cache_flush(cache_flush),
        .cache_valid(cache_valid), .cache_ready(cache_ready),
        .cache_addr(cache_addr), .cache_rdata(cache_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy)
`ifdef ICACHE_STATS_EN
       ,.hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: each word holds its own address xor a pattern.
    assign mem_rdata = mem_addr ^ PAT;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] sb_q[$];
    logic [31:0] beat_log[$];
    logic [31:0] exp_beats[$];
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;
    int          stall_seen = 0;

    task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h want %h", tg, obs, exp);
        else n_pass++;
    endtask

    // Response monitor: scoreboard pop and refill beat logging.
    initial forever begin
        @(negedge clk);
        if (cache_valid && cache_ready) begin
            if (sb_q.size() == 0) check("sb_unexpected_ready", 32'd1, 32'd0);
            else check("rdata", cache_rdata, sb_q.pop_front());
        end
        if (mem_valid && mem_ready) beat_log.push_back(mem_addr);
        if (mem_valid && !mem_ready && mem_addr == stall_addr) stall_seen++;
    end

    // Memory ready generator: stalls the beat at stall_addr for stall_left cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (mem_valid && mem_addr == stall_addr && stall_left > 0) begin
            mem_ready = 1'b0;
            stall_left--;
        end else begin
            mem_ready = 1'b1;
        end
    end

    task automatic push_line(input logic [31:0] a);
        for (int i = 0; i < 4; i++) exp_beats.push_back({a[31:4], 4'h0} + 32'(4*i));
    endtask

    task automatic check_beats(input string tg);
        check({tg, "_nbeats"}, 32'(beat_log.size()), 32'(exp_beats.size()));
        while (beat_log.size() > 0 && exp_beats.size() > 0)
            check({tg, "_beat"}, beat_log.pop_front(), exp_beats.pop_front());
        beat_log.delete();
        exp_beats.delete();
    endtask

    // Holds the request until ready; optional flush/reset pulse in a given cycle.
    task automatic fetch(input string tg, input logic [31:0] a, input int exp_lat,
                         input int flush_cyc, input int rst_cyc);
        int n;
        n = 0;
        cache_valid = 1'b1;
        cache_addr  = a;
        cache_flush = (flush_cyc == 0);
        sb_q.push_back({a[31:2], 2'b00} ^ PAT);
        forever begin
            @(negedge clk);
            if (rst_cyc >= 0 && n == rst_cyc + 1) begin
                check({tg, "_rst_mem_valid"}, 32'(mem_valid), 32'd0);
                check({tg, "_rst_busy"}, 32'(busy), 32'd0);
            end
            if (cache_ready) break;
            if (n >= 200) begin
                check({tg, "_timeout"}, 32'(n), 32'(exp_lat));
                void'(sb_q.pop_back());
                break;
            end
            @(posedge clk);
            #1;
            n++;
            cache_flush = (n == flush_cyc);
            rst         = (n == rst_cyc);
        end
        check({tg, "_lat"}, 32'(n), 32'(exp_lat));
        @(posedge clk);
        #1;
        cache_valid = 1'b0;
        cache_flush = 1'b0;
        rst         = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(cache_ready), 32'd0);
        check("reset_mem_valid", 32'(mem_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        push_line(32'h108);
        fetch("cold", 32'h108, 5, -1, -1);
        check_beats("cold");
        fetch("hit_10c", 32'h10C, 0, -1, -1);
        fetch("hit_100", 32'h100, 0, -1, -1);
        check_beats("hits");
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, 32'd3);
        check("miss_count", miss_count, 32'd1);
`endif

        push_line(32'h500);
        fetch("conflict_500", 32'h500, 5, -1, -1);
        push_line(32'h100);
        fetch("conflict_100", 32'h100, 5, -1, -1);
        check_beats("conflict");

        push_line(32'h1230);
        fetch("idx3", 32'h1234, 5, -1, -1);
        check_beats("idx3");

        stall_addr = 32'h2008;
        stall_left = 3;
        stall_seen = 0;
        push_line(32'h2000);
        fetch("stall", 32'h2000, 8, -1, -1);
        check("stall_cycles", 32'(stall_seen), 32'd3);
        fetch("stall_hit", 32'h2008, 0, -1, -1);
        check_beats("stall");
        stall_addr = 32'hFFFF_FFFF;

        push_line(32'h3000);
        push_line(32'h3000);
        fetch("flush_beat0", 32'h3004, 10, 1, -1);
        check_beats("flush_beat0");

        push_line(32'h1230);
        fetch("flushed_line", 32'h1234, 5, -1, -1);
        check_beats("flushed_line");

        fetch("hit_with_flush", 32'h1238, 0, 0, -1);
        push_line(32'h1230);
        fetch("after_idle_flush", 32'h1238, 5, -1, -1);
        check_beats("idle_flush");

        push_line(32'h7000);
        push_line(32'h7000);
        fetch("flush_last_beat", 32'h700C, 10, 4, -1);
        check_beats("flush_last");

        exp_beats.push_back(32'h4000);
        exp_beats.push_back(32'h4004);
        exp_beats.push_back(32'h4008);
        push_line(32'h4000);
        fetch("rst_mid", 32'h4008, 9, -1, 3);
        check_beats("rst_mid");

        push_line(32'h7000);
        fetch("post_rst", 32'h700C, 5, -1, -1);
        check_beats("post_rst");

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
